// File: rtl/register_read.sv
// register_read: register-read stage between instruction decode and execute.
//
// Takes one decoded 16-bit instruction per cycle, reads the register file,
// builds the operand packet and registers it toward execute. Owns the
// register-file write port used by writeback, inserts a one-cycle bubble on a
// load-use hazard against execute, and honours downstream stall and flush.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    upstream handshake for instr / pc_in
//   instr, pc_in           instruction word and its PC (R7 reads as pc_in)
//   out_valid / out_ready  downstream handshake for the packet below
//   instr_out              {op[40:37], dest[36:34], opA[33:18], opB[17:2], cz[1:0]}
//   wr_en_out              packet writes a destination register
//   store_data             SW store data, R[ra]
//   illegal                opcode not handled by this stage
//   flush                  discard the input and the output packet
//   ex_valid, ex_is_load,
//   ex_dest                instruction currently in execute, for load-use
//   wb_en, wb_addr,
//   wb_data                register-file write port
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is combinational from flush, the hazard check,
// out_ready and out_valid. While out_valid=1 and out_ready=0 every output
// is held unchanged. A flush, or a cycle with no accepted input, drops
// out_valid (and wr_en_out) at the next edge.
module register_read #(
    parameter int NREGS = 8,
    parameter int XLEN  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [XLEN-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*XLEN+8:0] instr_out,
    output logic              wr_en_out,
    output logic [XLEN-1:0]   store_data,
    output logic              illegal,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_dest,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1100;
    localparam logic [2:0] PC_REG = 3'd7;

    // R0..R(NREGS-2) are real storage; the last architectural register is the PC.
    logic [XLEN-1:0]   rf_q [NREGS-1];
    logic [XLEN-1:0]   rf_d [NREGS-1];

    logic              out_valid_q, out_valid_d;
    logic [2*XLEN+8:0] instr_out_q, instr_out_d;
    logic              wr_en_out_q, wr_en_out_d;
    logic [XLEN-1:0]   store_data_q, store_data_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        op;
    logic [2:0]        ra, rb, rc;
    logic [XLEN-1:0]   rd_a, rd_b;
    logic [XLEN-1:0]   imm6_sx, lhi_val;
    logic [XLEN-1:0]   p_a, p_b, p_st;
    logic [2:0]        p_dest;
    logic [1:0]        p_cz;
    logic              p_wr, p_ill;
    logic              use_ra, use_rb;
    logic              hazard;
    logic              accept;

    assign op      = instr[15:12];
    assign ra      = instr[11:9];
    assign rb      = instr[8:6];
    assign rc      = instr[5:3];
    assign imm6_sx = {{(XLEN-6){instr[5]}}, instr[5:0]};
    assign lhi_val = {instr[8:0], 7'b0};

    // Read ports: PC first, then same-cycle writeback bypass, then storage.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (ra == PC_REG)                 rd_a = pc_in;
        else if (wb_en && wb_addr == ra)  rd_a = wb_data;
        else                              rd_a = rf_q[ra];
        if (rb == PC_REG)                 rd_b = pc_in;
        else if (wb_en && wb_addr == rb)  rd_b = wb_data;
        else                              rd_b = rf_q[rb];
    end

    // Operand build and source-usage decode.
    always_comb begin
        p_a    = '0;
        p_b    = '0;
        p_st   = '0;
        p_dest = 3'd0;
        p_cz   = 2'b00;
        p_wr   = 1'b0;
        p_ill  = 1'b0;
        use_ra = 1'b0;
        use_rb = 1'b0;
        case (op)
            OP_ADD, OP_NDU: begin
                p_a = rd_a; p_b = rd_b; p_dest = rc; p_wr = 1'b1; p_cz = instr[1:0];
                use_ra = 1'b1; use_rb = 1'b1;
            end
            OP_ADI: begin
                p_a = rd_a; p_b = imm6_sx; p_dest = rb; p_wr = 1'b1;
                use_ra = 1'b1;
            end
            OP_LHI: begin
                p_b = lhi_val; p_dest = ra; p_wr = 1'b1;
            end
            OP_LW: begin
                p_a = rd_b; p_b = imm6_sx; p_dest = ra; p_wr = 1'b1;
                use_rb = 1'b1;
            end
            OP_SW: begin
                p_a = rd_b; p_b = imm6_sx; p_st = rd_a;
                use_ra = 1'b1; use_rb = 1'b1;
            end
            OP_BEQ: begin
                p_a = rd_a; p_b = rd_b;
                use_ra = 1'b1; use_rb = 1'b1;
            end
            default: p_ill = 1'b1;
        endcase
    end

    // A load in execute cannot forward in time; R7 never comes from a load.
    assign hazard = in_valid && ex_valid && ex_is_load && (ex_dest != PC_REG) &&
                    ((use_ra && ex_dest == ra) || (use_rb && ex_dest == rb));

    assign in_ready = !flush && !hazard && (out_ready || !out_valid_q);
    assign accept   = in_valid && in_ready;

    // Output packet: flush beats stall beats load; otherwise a bubble.
    always_comb begin
        out_valid_d  = out_valid_q;
        instr_out_d  = instr_out_q;
        wr_en_out_d  = wr_en_out_q;
        store_data_d = store_data_q;
        illegal_d    = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
            wr_en_out_d = 1'b0;
        end else if (out_valid_q && !out_ready) begin
            // stalled: hold everything
        end else if (accept) begin
            out_valid_d  = 1'b1;
            instr_out_d  = {op, p_dest, p_a, p_b, p_cz};
            wr_en_out_d  = p_wr;
            store_data_d = p_st;
            illegal_d    = p_ill;
        end else begin
            out_valid_d = 1'b0;
            wr_en_out_d = 1'b0;
        end
    end

    // Register-file write port; writes to R7 are dropped, flush does not block writes.
    always_comb begin
        for (int i = 0; i < NREGS - 1; i++) begin
            rf_d[i] = rf_q[i];
            if (wb_en && wb_addr == 3'(i)) rf_d[i] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            instr_out_q  <= '0;
            wr_en_out_q  <= 1'b0;
            store_data_q <= '0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NREGS - 1; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            instr_out_q  <= instr_out_d;
            wr_en_out_q  <= wr_en_out_d;
            store_data_q <= store_data_d;
            illegal_q    <= illegal_d;
            for (int i = 0; i < NREGS - 1; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign out_valid  = out_valid_q;
    assign instr_out  = instr_out_q;
    assign wr_en_out  = wr_en_out_q;
    assign store_data = store_data_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_register_read.sv
module tb_register_read;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [40:0] instr_out;
  logic        wr_en_out;
  logic [15:0] store_data;
  logic        illegal;
  logic        flush;
  logic        ex_valid;
  logic        ex_is_load;
  logic [2:0]  ex_dest;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  always #5 clk = ~clk;

  register_read dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .wr_en_out(wr_en_out), .store_data(store_data), .illegal(illegal),
    .flush(flush), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int checks = 0;
  int errors = 0;

  // reference state: architectural registers and the expected output packet
  logic [15:0] mrf [0:7];
  logic        e_valid;
  logic        e_wr;
  logic        e_ill;
  logic [40:0] e_pkt;
  logic [15:0] e_st;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mread(input logic [2:0] a);
    if (a == 3'd7) return pc_in;
    if (wb_en && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  function automatic logic [15:0] sx6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  // Expected packet for the current instr, plus which registers it reads.
  task automatic model_decode(output logic [40:0] pkt, output logic wr, output logic [15:0] st,
                              output logic ill, output logic [7:0] used);
    logic [3:0]  op;
    logic [2:0]  ra, rb, rc, dest;
    logic [15:0] a, b;
    logic [1:0]  cz;
    op = instr[15:12]; ra = instr[11:9]; rb = instr[8:6]; rc = instr[5:3];
    a = 0; b = 0; dest = 0; cz = 0; wr = 0; st = 0; ill = 0; used = 0;
    case (op)
      4'b0000, 4'b0010: begin a = mread(ra); b = mread(rb); dest = rc; wr = 1; cz = instr[1:0];
                              used[ra] = 1; used[rb] = 1; end
      4'b0001: begin a = mread(ra); b = sx6(instr[5:0]); dest = rb; wr = 1; used[ra] = 1; end
      4'b0011: begin b = {instr[8:0], 7'b0}; dest = ra; wr = 1; end
      4'b0100: begin a = mread(rb); b = sx6(instr[5:0]); dest = ra; wr = 1; used[rb] = 1; end
      4'b0101: begin a = mread(rb); b = sx6(instr[5:0]); st = mread(ra);
                     used[ra] = 1; used[rb] = 1; end
      4'b1100: begin a = mread(ra); b = mread(rb); used[ra] = 1; used[rb] = 1; end
      default: ill = 1;
    endcase
    pkt = {op, dest, a, b, cz};
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    logic [40:0] p;
    logic        w, i, hz, rdy;
    logic [15:0] s;
    logic [7:0]  used;
    #1;
    model_decode(p, w, s, i, used);
    hz  = in_valid && ex_valid && ex_is_load && ex_dest != 3'd7 && used[ex_dest];
    rdy = !flush && !hz && (out_ready || !e_valid);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (flush) begin
      e_valid = 0; e_wr = 0;
    end else if (e_valid && !out_ready) begin
      // held
    end else if (in_valid && rdy) begin
      e_valid = 1; e_pkt = p; e_wr = w; e_st = s; e_ill = i;
    end else begin
      e_valid = 0; e_wr = 0;
    end
    if (wb_en && wb_addr != 3'd7) mrf[wb_addr] = wb_data;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("wr_en_out", 64'(wr_en_out), 64'(e_wr));
    if (e_valid) begin
      chk("instr_out", 64'(instr_out), 64'(e_pkt));
      chk("store_data", 64'(store_data), 64'(e_st));
      chk("illegal", 64'(illegal), 64'(e_ill));
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [5:0] low);
    return {op, ra, rb, low};
  endfunction

  task automatic idle_inputs();
    in_valid = 0; instr = 0; pc_in = 16'h0100; out_ready = 1; flush = 0;
    ex_valid = 0; ex_is_load = 0; ex_dest = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mrf[k] = 16'h0;
    e_valid = 0; e_wr = 0; e_ill = 0; e_pkt = 0; e_st = 0;
  endtask

  logic [15:0] dir_instrs [6];

  initial begin
    // clock/reset
    idle_inputs();
    model_reset();
    rst_n = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr_out", 64'(instr_out), 64'd0);
    chk("rst_wr_en_out", 64'(wr_en_out), 64'd0);
    chk("rst_store_data", 64'(store_data), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    rst_n = 1;
    @(negedge clk);

    // write R3, then ADD reads it
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'h1234;
    tick();
    wb_en = 0;
    in_valid = 1; instr = mk(4'b0000, 3'd3, 3'd0, 6'b101_000);
    tick();
    chk("add_pkt_const", 64'(instr_out), 64'({4'b0000, 3'b101, 16'h1234, 16'h0000, 2'b00}));
    chk("add_wr_const", 64'(wr_en_out), 64'd1);

    // same-cycle writeback bypass into ADI
    wb_en = 1; wb_addr = 3'd2; wb_data = 16'hBEEF;
    instr = mk(4'b0001, 3'd2, 3'd6, 6'h3F);
    tick();
    wb_en = 0;
    chk("adi_opA", 64'(instr_out[33:18]), 64'h0000_0000_0000_BEEF);
    chk("adi_opB", 64'(instr_out[17:2]), 64'h0000_0000_0000_FFFF);
    chk("adi_dest", 64'(instr_out[36:34]), 64'd6);

    // load-use: one bubble, then issue
    ex_valid = 1; ex_is_load = 1; ex_dest = 3'd4;
    instr = mk(4'b0000, 3'd4, 3'd1, 6'b010_000);
    tick();
    chk("bubble_out_valid", 64'(out_valid), 64'd0);
    ex_valid = 0;
    tick();
    chk("after_bubble_valid", 64'(out_valid), 64'd1);

    // three-cycle stall with a new instruction waiting
    out_ready = 0; instr = mk(4'b0010, 3'd3, 3'd2, 6'b111_011);
    for (int k = 0; k < 3; k++) tick();
    out_ready = 1;
    tick();

    // flush while stalled and hazarded; register write still lands
    out_ready = 0; ex_valid = 1; ex_is_load = 1; ex_dest = 3'd4;
    instr = mk(4'b0000, 3'd4, 3'd5, 6'b001_000);
    flush = 1; wb_en = 1; wb_addr = 3'd5; wb_data = 16'h5A5A;
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    flush = 0; wb_en = 0; ex_valid = 0; out_ready = 1;
    tick();

    // remaining opcode classes, including R7 writes being dropped
    wb_en = 1; wb_addr = 3'd7; wb_data = 16'hDEAD; pc_in = 16'h0042;
    dir_instrs[0] = mk(4'b0101, 3'd2, 3'd3, 6'h3E);
    dir_instrs[1] = mk(4'b0011, 3'd1, 3'b101, 6'h2A);
    dir_instrs[2] = mk(4'b1100, 3'd7, 3'd5, 6'h00);
    dir_instrs[3] = mk(4'b0100, 3'd0, 3'd7, 6'h1F);
    dir_instrs[4] = mk(4'b1111, 3'd3, 3'd3, 6'h3F);
    dir_instrs[5] = mk(4'b0010, 3'd5, 3'd7, 6'b000_011);
    for (int k = 0; k < 6; k++) begin
      instr = dir_instrs[k];
      tick();
    end
    wb_en = 0;

    // asynchronous reset mid-stream
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_wr_en", 64'(wr_en_out), 64'd0);
    chk("mid_rst_instr_out", 64'(instr_out), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; instr = mk(4'b0000, 3'd5, 3'd3, 6'b001_000);
    tick();
    chk("post_rst_R5", 64'(instr_out[33:18]), 64'd0);
    pc_in = 16'hABCD; instr = mk(4'b0000, 3'd7, 3'd2, 6'b001_000);
    tick();
    chk("post_rst_R7_pc", 64'(instr_out[33:18]), 64'h0000_0000_0000_ABCD);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 7))
        0: op = 4'b0000; 1: op = 4'b0001; 2: op = 4'b0010; 3: op = 4'b0011;
        4: op = 4'b0100; 5: op = 4'b0101; 6: op = 4'b1100;
        default: op = 4'($urandom_range(0, 15));
      endcase
      in_valid   = $urandom_range(0, 3) != 0;
      instr      = {op, 12'($urandom_range(0, 4095))};
      pc_in      = 16'($urandom_range(0, 65535));
      out_ready  = $urandom_range(0, 3) != 0;
      flush      = $urandom_range(0, 15) == 0;
      ex_valid   = $urandom_range(0, 1) == 1;
      ex_is_load = $urandom_range(0, 1) == 1;
      ex_dest    = 3'($urandom_range(0, 7));
      wb_en      = $urandom_range(0, 1) == 1;
      wb_addr    = 3'($urandom_range(0, 7));
      wb_data    = 16'($urandom_range(0, 65535));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
